// File: rtl/fifo_push_arbiter_if.sv
// Requester/FIFO-side signal bundle for fifo_push_arbiter.
// slave is the arbiter's view; master is the requester/FIFO environment's view.
interface fifo_push_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_push;
  logic [DATA_WIDTH-1:0]         fifo_push_data;
  logic                          fifo_full;
  logic [GW-1:0]                 grant_id;
  logic                          busy;

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_push, fifo_push_data, grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_push, fifo_push_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter funnelling packets from NUM_REQ requesters into one FIFO push port.
// state | meaning
// IDLE  | no grant held; pick next requester round-robin, no beats accepted
// XFER  | grantee owns the FIFO until its last beat or MAX_BURST beats
module fifo_push_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16
) (
  input logic                clk,
  input logic                reset,
  fifo_push_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d, beat_cnt_inc;
  logic [GW-1:0]         winner, cand;
  logic                  found;
  logic                  g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic [NUM_REQ-1:0]    ready;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;

  // Search starts one past the previous grantee so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) g_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign g_valid      = bus.req_valid[grant_q];
  assign g_last       = bus.req_last[grant_q];
  assign beat_cnt_inc = beat_cnt_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    ready        = '0;
    push         = 1'b0;
    push_data    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = winner;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        ready[grant_q] = ~bus.fifo_full;
        push           = g_valid & ~bus.fifo_full;
        push_data      = g_data;
        if (push) begin
          beat_cnt_d = beat_cnt_inc;
          // Burst cap releases the grant even mid-packet; the rest re-arbitrates.
          if (g_last || beat_cnt_inc == BURST_END) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready      = ready;
  assign bus.fifo_push      = push;
  assign bus.fifo_push_data = push_data;
  assign bus.grant_id       = grant_q;
  assign bus.busy           = (state_q == XFER);
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench: per-cycle comparison against a packet-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_push_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  fifo_push_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  fifo_push_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // requester beat queues and stimulus knobs
  logic [DW-1:0] qd [NR][$];
  logic          ql [NR][$];
  int            seq [NR];
  logic [NR-1:0] offer = '0;
  int            gap_pct = 0, full_pct = 0;
  bit            auto_fill = 1'b0;
  int            stall_at = -1, stall_len = 0, stall_left = 0, stall_kind = 0, stall_req = 0;

  // observed pushes and expected pushes for directed scenarios
  int            push_id [$];
  logic [DW-1:0] push_dat [$];
  int            push_cyc [$];
  int            eid [$];
  int            edat [$];

  // reference model state: owner = -1 when nobody holds the FIFO
  int m_owner = -1, m_last = NR - 1, m_gid = 0, m_cnt = 0, m_c = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_owner = -1; m_last = NR - 1; m_gid = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        m_c = (m_last + k) % NR;
        if (m_owner < 0 && bus.req_valid[m_c]) begin
          m_owner = m_c; m_gid = m_c; m_cnt = 0;
        end
      end
    end else if (bus.req_valid[m_owner] && !bus.fifo_full) begin
      m_cnt = m_cnt + 1;
      if (bus.req_last[m_owner] || m_cnt == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  // compare + push monitor, sampled mid-cycle
  initial forever begin
    logic [NR-1:0] er;
    logic          ep;
    logic [DW-1:0] ed;
    @(negedge clk);
    er = '0; ep = 1'b0; ed = '0;
    if (!reset && m_owner >= 0) begin
      er[m_owner] = !bus.fifo_full;
      ep = bus.req_valid[m_owner] && !bus.fifo_full;
      ed = bus.req_data[m_owner*DW +: DW];
    end
    chk("busy", bus.busy, (!reset && m_owner >= 0));
    chk("grant_id", bus.grant_id, m_gid);
    chk("req_ready", bus.req_ready, er);
    chk("fifo_push", bus.fifo_push, ep);
    chk("fifo_push_data", bus.fifo_push_data, ed);
    if (bus.fifo_push) begin
      push_id.push_back(int'(bus.grant_id));
      push_dat.push_back(bus.fifo_push_data);
      push_cyc.push_back(cyc);
    end
  end

  task automatic add_packet(input int i, input int len, input bit with_last);
    for (int b = 0; b < len; b++) begin
      qd[i].push_back(DW'((i << 6) | (seq[i] & 63)));
      ql[i].push_back(with_last && (b == len - 1));
      seq[i]++;
    end
  endtask

  task automatic drive();
    logic [NR-1:0]    v, l;
    logic [NR*DW-1:0] d;
    bit               stalling;
    if (auto_fill)
      for (int i = 0; i < NR; i++)
        while (qd[i].size() < 4) add_packet(i, int'($urandom_range(1, 20)), 1'b1);
    stalling = 1'b0;
    if (stall_at >= 0 && push_id.size() == stall_at) begin
      stall_left = stall_len;
      stall_at   = -1;
    end
    if (stall_left > 0) begin
      stalling = 1'b1;
      stall_left--;
    end
    for (int i = 0; i < NR; i++) begin
      v[i] = offer[i] && qd[i].size() > 0 && ($urandom_range(0, 99) >= gap_pct)
             && !(stalling && stall_kind == 1 && stall_req == i);
      d[i*DW +: DW] = (qd[i].size() > 0) ? qd[i][0] : DW'($urandom);
      l[i] = (ql[i].size() > 0) ? ql[i][0] : 1'($urandom);
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    bus.fifo_full = (stalling && stall_kind == 0) || ($urandom_range(0, 99) < full_pct);
  endtask

  // requester BFM: pops a beat once it has been handshaken
  initial forever begin
    logic [NR-1:0] fired;
    @(negedge clk);
    fired = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    if (!reset)
      for (int i = 0; i < NR; i++)
        if (fired[i] && qd[i].size() > 0) begin
          qd[i].delete(0);
          ql[i].delete(0);
        end
    drive();
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    offer = '0; auto_fill = 1'b0; gap_pct = 0; full_pct = 0;
    stall_at = -1; stall_left = 0;
    for (int i = 0; i < NR; i++) begin
      qd[i].delete(); ql[i].delete(); seq[i] = 0;
    end
    push_id.delete(); push_dat.delete(); push_cyc.delete();
    eid.delete(); edat.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_pushes(input string name, input int n, input int budget);
    int t = 0;
    while (push_id.size() < n && t < budget) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk({name, " push count reached"}, push_id.size() >= n, 1);
  endtask

  task automatic expect_beat(input int id, input int data);
    eid.push_back(id);
    edat.push_back(data);
  endtask

  task automatic check_log(input string name);
    for (int k = 0; k < eid.size() && k < push_id.size(); k++) begin
      chk($sformatf("%s id[%0d]", name, k), push_id[k], eid[k]);
      chk($sformatf("%s data[%0d]", name, k), push_dat[k], edat[k]);
    end
  endtask

  task automatic check_gap(input string name, input int k, input int exp);
    if (push_cyc.size() > k)
      chk($sformatf("%s gap[%0d]", name, k), push_cyc[k] - push_cyc[k-1], exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    #2;
    chk("reset busy", bus.busy, 0);
    chk("reset fifo_push", bus.fifo_push, 0);
    chk("reset req_ready", bus.req_ready, 0);
    chk("reset grant_id", bus.grant_id, 0);

    // all four requesters, 2-beat packets: 0,1,2,3,0 with one idle cycle between grants
    do_reset();
    for (int i = 0; i < NR; i++) begin
      add_packet(i, 2, 1'b1);
      add_packet(i, 2, 1'b1);
    end
    offer = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      expect_beat(g % 4, ((g % 4) << 6) | (g / 4) * 2);
      expect_beat(g % 4, ((g % 4) << 6) | (g / 4) * 2 + 1);
    end
    wait_pushes("rr", 10, 100);
    check_log("rr");
    for (int k = 1; k < 10; k++) check_gap("rr", k, (k % 2 == 1) ? 1 : 2);

    // FIFO full for 3 cycles after beat 2 of requester 2's 5-beat packet
    do_reset();
    add_packet(2, 5, 1'b1);
    offer = 4'b0100;
    stall_kind = 0; stall_len = 3; stall_at = 2;
    for (int b = 0; b < 5; b++) expect_beat(2, 8'h80 + b);
    wait_pushes("full", 5, 100);
    check_log("full");
    check_gap("full", 1, 1);
    check_gap("full", 2, 4);
    check_gap("full", 3, 1);

    // burst cap: 20 unterminated beats from 1, one packet from 3
    do_reset();
    add_packet(1, 20, 1'b0);
    add_packet(3, 2, 1'b1);
    offer = 4'b1010;
    for (int b = 0; b < 16; b++) expect_beat(1, 8'h40 + b);
    expect_beat(3, 8'hC0);
    expect_beat(3, 8'hC1);
    for (int b = 16; b < 20; b++) expect_beat(1, 8'h40 + b);
    wait_pushes("burst", 22, 200);
    check_log("burst");
    check_gap("burst", 16, 2);
    check_gap("burst", 18, 2);

    // grantee 0 drops valid for 4 cycles; requester 1 must wait
    do_reset();
    add_packet(0, 6, 1'b1);
    add_packet(1, 2, 1'b1);
    offer = 4'b0011;
    stall_kind = 1; stall_req = 0; stall_len = 4; stall_at = 2;
    for (int b = 0; b < 6; b++) expect_beat(0, b);
    expect_beat(1, 8'h40);
    expect_beat(1, 8'h41);
    wait_pushes("drop", 8, 100);
    check_log("drop");
    check_gap("drop", 2, 5);
    check_gap("drop", 6, 2);

    // reset in the middle of beat 3 of an 8-beat packet
    do_reset();
    add_packet(1, 8, 1'b1);
    offer = 4'b0010;
    wait_pushes("midrst", 2, 50);
    @(negedge clk);
    chk("midrst beat3 in flight", bus.fifo_push, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst busy", bus.busy, 0);
    chk("midrst fifo_push", bus.fifo_push, 0);
    chk("midrst req_ready", bus.req_ready, 0);
    do_reset();
    add_packet(0, 1, 1'b1);
    add_packet(1, 1, 1'b1);
    offer = 4'b0011;
    expect_beat(0, 8'h00);
    expect_beat(1, 8'h40);
    wait_pushes("midrst", 2, 50);
    check_log("midrst");

    // single-beat packets from 0 and 3 alternate
    do_reset();
    for (int r = 0; r < 3; r++) begin
      add_packet(0, 1, 1'b1);
      add_packet(3, 1, 1'b1);
      expect_beat(0, r);
      expect_beat(3, 8'hC0 + r);
    end
    offer = 4'b1001;
    wait_pushes("single", 6, 60);
    check_log("single");

    // randomized traffic with backpressure, gaps and an asynchronous reset
    do_reset();
    auto_fill = 1'b1; offer = 4'b1111; gap_pct = 20; full_pct = 25;
    repeat (1500) @(negedge clk);
    chk("random progress", push_id.size() > 200, 1);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("random reset busy", bus.busy, 0);
    chk("random reset fifo_push", bus.fifo_push, 0);
    do_reset();
    auto_fill = 1'b1; offer = 4'b1111; gap_pct = 60; full_pct = 10;
    repeat (1000) @(negedge clk);
    chk("random progress 2", push_id.size() > 100, 1);
    auto_fill = 1'b0;
    offer = '0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of one data beat.
REQ-002 The block SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-003 The block SHALL have parameter MAX_BURST, default 16: maximum beats per grant, legal range 1..256.
REQ-004 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: reset, asynchronous, active-high.
REQ-006 Port req_valid, input, NUM_REQ: bit i set means requester i offers a beat.
REQ-007 Port req_data, input, NUM_REQ*DATA_WIDTH: requester i's beat on bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port req_last, input, NUM_REQ: bit i marks requester i's beat as the final beat of its packet.
REQ-009 Port req_ready, output, NUM_REQ: bit i set means requester i's beat is accepted this cycle.
REQ-010 Port fifo_push, output, 1: push strobe to the shared FIFO.
REQ-011 Port fifo_push_data, output, DATA_WIDTH: data to the shared FIFO.
REQ-012 Port fifo_full, input, 1: full flag from the shared FIFO.
REQ-013 Port grant_id, output, $clog2(NUM_REQ): index of the current or most recent grantee.
REQ-014 Port busy, output, 1: high while in XFER.

Function
REQ-015 The block SHALL implement a two-state FSM with states IDLE and XFER.
REQ-016 In IDLE with any req_valid bit set, the block SHALL select a winner round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap, register it in grant_id, and enter XFER on the next edge.
REQ-017 In IDLE with req_valid all zero, the block SHALL remain in IDLE and leave grant_id unchanged.
REQ-018 Arbitration latency SHALL be exactly one cycle: req_ready SHALL NOT assert in the cycle the winner is chosen.
REQ-019 In XFER, req_ready[grant_id] SHALL equal ~fifo_full; all other req_ready bits SHALL be 0.
REQ-020 In IDLE, every req_ready bit and fifo_push SHALL be 0.
REQ-021 fifo_push SHALL equal req_valid[grant_id] & req_ready[grant_id], combinationally.
REQ-022 fifo_push_data SHALL be the grantee's req_data slice in XFER; in IDLE it SHALL be all zeros.
REQ-023 A beat transfers when fifo_push is 1; each transfer SHALL increment the beat counter, which clears on entry to XFER.
REQ-024 While fifo_full is 1, the block SHALL push nothing and hold state, grant, and beat count.
REQ-025 If the grantee deasserts req_valid mid-packet, the block SHALL keep the grant and wait in XFER indefinitely.
REQ-026 A transfer with req_last=1 SHALL return the FSM to IDLE on that edge and set last_grant to grant_id.
REQ-027 A transfer that brings the beat count to MAX_BURST SHALL return the FSM to IDLE and update last_grant, even when req_last=0.
REQ-028 After a MAX_BURST release, the interrupted requester SHALL re-arbitrate normally; its remaining beats are not prioritised.
REQ-029 Beats from different requesters SHALL never interleave within a single grant.
REQ-030 Inputs from non-granted requesters SHALL have no effect during XFER.

Reset
REQ-031 On reset the block SHALL set state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), grant_id=0, beat counter=0, and busy=0.
REQ-032 During reset, req_ready and fifo_push SHALL be 0.
REQ-033 Reset mid-packet SHALL abandon the packet and return to IDLE with no partial state retained.

Verification
REQ-034 Scenario: reset release, req_valid=4'b1111 held, every packet 2 beats, fifo_full=0 -> grants in order 0,1,2,3,0; each grant pushes exactly 2 beats, separated by 1 idle arbitration cycle.
REQ-035 Scenario: requester 2 sends a 5-beat packet, fifo_full raised for 3 cycles after beat 2 -> no push while full, beats 3-5 follow in order, grant_id=2 throughout.
REQ-036 Scenario: MAX_BURST=16, requester 1 sends 20 beats with no last, requester 3 valid -> 16 beats from 1, then 3's packet, then 1's last 4 beats.
REQ-037 Scenario: grantee 0 drops req_valid for 4 cycles mid-packet while requester 1 is valid -> requester 1 gets no req_ready; requester 0 resumes and completes.
REQ-038 Scenario: reset asserted during beat 3 of an 8-beat packet -> busy=0 and fifo_push=0 immediately; the next grant goes to requester 0.
REQ-039 Scenario: single-beat packets (req_last=1 on every beat) from requesters 0 and 3 only -> grants alternate 0,3,0,3; FIFO contents match the data in that order.
